// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// The transmit FIFO and its feed FSM import this package.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_TXFIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_LO,
    WAIT_HI
  } tx_feed_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular buffer with wrap-bit pointers, level decode and a sticky overflow flag.
// flush discards queued entries and blocks any push or pop in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH  = UART_TXFIFO_DEPTH,
  parameter int  DATA_W = UART_DATA_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int PW     = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [PW-1:0]     level,
  output logic              overflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              push;
  logic              pop;

  // A push is refused while full even if a pop lands in the same cycle.
  assign push    = wr_en && !full && !flush;
  assign pop     = rd_en && !empty && !flush;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign rd_data = mem[rptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define what is valid,
  // and leaving it reset-free lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rptr     <= wptr;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_ovf)  overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit queue plus feed FSM: hands one byte at a time to the UART transmitter and
// waits for accept (clear_start_tx) and a full tx_done low/high cycle before the next.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_TXFIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   flush,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   start_tx,
  input  logic                   clear_start_tx,
  input  logic                   tx_done
);

  tx_feed_state_e    state;
  logic [DATA_W-1:0] head;
  logic              pop;

  // Pop only from registered state and pointers, so wr_en never reaches start_tx combinationally.
  assign pop = (state == IDLE) && !empty && tx_done && !flush;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // The WAIT_LO/WAIT_HI handshake keeps start_tx from re-asserting while a frame is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      start_tx <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= head;
            start_tx <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (clear_start_tx) begin
            start_tx <= 1'b0;
            state    <= WAIT_LO;
          end
        end
        WAIT_LO: if (!tx_done) state <= WAIT_HI;
        WAIT_HI: if (tx_done)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model (accept pulse, busy window).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       full, empty, overflow, start_tx;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       clear_start_tx, tx_done;

  logic       model_en = 1'b0;
  logic       tb_clr = 1'b0;
  logic       tb_done = 1'b1;
  logic       m_clr = 1'b0;
  logic       m_done = 1'b1;
  int         phase = 0;
  int         mcnt = 0;
  int         cap_cnt = 0;
  logic [7:0] cap_mem [256];
  logic [4:0] cap_lvl [256];
  int         start_cnt = 0;
  logic       prev_start = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  assign clear_start_tx = model_en ? m_clr : tb_clr;
  assign tx_done        = model_en ? m_done : tb_done;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .flush          (flush),
    .clr_ovf        (clr_ovf),
    .full           (full),
    .empty          (empty),
    .level          (level),
    .overflow       (overflow),
    .tx_data        (tx_data),
    .start_tx       (start_tx),
    .clear_start_tx (clear_start_tx),
    .tx_done        (tx_done)
  );

  // Transmitter model: accept pulse, tx_done low 3 cycles later, high again 5 cycles after that.
  always @(negedge clk) begin
    if (!model_en) begin
      m_clr = 1'b0;
      m_done = 1'b1;
      phase = 0;
      mcnt = 0;
    end else begin
      case (phase)
        0: if (start_tx) begin
          m_clr = 1'b1;
          if (cap_cnt < 256) begin
            cap_mem[cap_cnt] = tx_data;
            cap_lvl[cap_cnt] = level;
          end
          cap_cnt++;
          phase = 1;
          mcnt = 0;
        end
        1: begin
          m_clr = 1'b0;
          mcnt++;
          if (mcnt == 3) begin m_done = 1'b0; phase = 2; mcnt = 0; end
        end
        default: begin
          mcnt++;
          if (mcnt == 5) begin m_done = 1'b1; phase = 0; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (start_tx && !prev_start) start_cnt++;
    prev_start = start_tx;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cap_cnt >= target && phase == 0 && m_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (start_tx !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b exp 0", start_tx); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h exp 00", tx_data); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rst_level: got %0d exp 0", level); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b exp 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b exp 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b exp 0", overflow); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_in_order();
    int base, sbase;
    bit ok;
    logic [7:0] exp_b [3];
    logic [4:0] exp_l [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    exp_l[0] = 5'd2;  exp_l[1] = 5'd1;  exp_l[2] = 5'd0;
    tb_done = 1'b0;
    base = cap_cnt;
    sbase = start_cnt;
    push(8'h41); push(8'h42); push(8'h43);
    n_cmp++; if (level !== 5'd3) begin n_bad++; $display("FAIL order_level3: got %0d exp 3", level); end
    model_en = 1'b1;
    wait_frames(base + 3, 500, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL order_timeout: frames=%0d exp 3", cap_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (cap_mem[base+i] !== exp_b[i]) begin n_bad++; $display("FAIL order_byte%0d: got %h exp %h", i, cap_mem[base+i], exp_b[i]); end
      n_cmp++; if (cap_lvl[base+i] !== exp_l[i]) begin n_bad++; $display("FAIL order_lvl%0d: got %0d exp %0d", i, cap_lvl[base+i], exp_l[i]); end
    end
    n_cmp++; if (start_cnt - sbase !== 3) begin n_bad++; $display("FAIL order_pulses: got %0d exp 3", start_cnt - sbase); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL order_empty: got %b exp 1", empty); end
  endtask

  task automatic test_overflow();
    int base;
    bit ok;
    model_en = 1'b0;
    tb_done = 1'b0;
    base = cap_cnt;
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL ovf_full16: got %b exp 1", full); end
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_level16: got %0d exp 16", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b exp 0", overflow); end
    push(8'hB0);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b exp 1", overflow); end
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_level17: got %0d exp 16", level); end
    wr_en = 1'b1; wr_data = 8'hB1; clr_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; clr_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins: got %b exp 1", overflow); end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
    model_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL ovf_pop_full: got %b exp 0", full); end
    n_cmp++; if (level !== 5'd15) begin n_bad++; $display("FAIL ovf_pop_level: got %0d exp 15", level); end
    n_cmp++; if (tx_data !== 8'hA0) begin n_bad++; $display("FAIL ovf_head: got %h exp a0", tx_data); end
    wait_frames(base + 16, 1000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ovf_timeout: frames=%0d exp 16", cap_cnt - base); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (cap_mem[base+i] !== 8'hA0 + 8'(i)) begin n_bad++; $display("FAIL ovf_byte%0d: got %h exp %h", i, cap_mem[base+i], 8'hA0 + 8'(i)); end
    end
    repeat (40) @(negedge clk);
    n_cmp++; if (cap_cnt - base !== 16) begin n_bad++; $display("FAIL ovf_no17th: frames=%0d exp 16", cap_cnt - base); end
  endtask

  task automatic test_same_cycle_wrap();
    int base, d, budget;
    bit ok;
    model_en = 1'b0;
    tb_done = 1'b0;
    base = cap_cnt;
    for (int i = 0; i < 5; i++) push(8'(i));
    n_cmp++; if (level !== 5'd5) begin n_bad++; $display("FAIL wrap_level5: got %0d exp 5", level); end
    model_en = 1'b1;
    push(8'h05);
    n_cmp++; if (level !== 5'd5) begin n_bad++; $display("FAIL wrap_pushpop: got %0d exp 5", level); end
    n_cmp++; if (start_tx !== 1'b1) begin n_bad++; $display("FAIL wrap_start: got %b exp 1", start_tx); end
    d = 6;
    budget = 0;
    while (d < 64 && budget < 2000) begin
      if (!full) begin wr_en = 1'b1; wr_data = 8'(d); d++; end
      else wr_en = 1'b0;
      @(negedge clk);
      budget++;
    end
    wr_en = 1'b0;
    n_cmp++; if (d !== 64) begin n_bad++; $display("FAIL wrap_push_timeout: pushed %0d exp 64", d); end
    wait_frames(base + 64, 2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wrap_timeout: frames=%0d exp 64", cap_cnt - base); end
    for (int i = 0; i < 64; i++) begin
      n_cmp++; if (cap_mem[base+i] !== 8'(i)) begin n_bad++; $display("FAIL wrap_byte%0d: got %h exp %h", i, cap_mem[base+i], 8'(i)); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf: got %b exp 0", overflow); end
  endtask

  task automatic test_flush_in_req();
    int base;
    bit ok;
    model_en = 1'b0;
    tb_done = 1'b1;
    tb_clr = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    n_cmp++; if (start_tx !== 1'b1) begin n_bad++; $display("FAIL flush_pre_start: got %b exp 1", start_tx); end
    n_cmp++; if (tx_data !== 8'h10) begin n_bad++; $display("FAIL flush_pre_data: got %h exp 10", tx_data); end
    n_cmp++; if (level !== 5'd4) begin n_bad++; $display("FAIL flush_pre_level: got %0d exp 4", level); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL flush_level: got %0d exp 0", level); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got %b exp 1", empty); end
    n_cmp++; if (start_tx !== 1'b1) begin n_bad++; $display("FAIL flush_start_kept: got %b exp 1", start_tx); end
    n_cmp++; if (tx_data !== 8'h10) begin n_bad++; $display("FAIL flush_data_kept: got %h exp 10", tx_data); end
    base = cap_cnt;
    model_en = 1'b1;
    wait_frames(base + 1, 200, ok);
    repeat (40) @(negedge clk);
    n_cmp++; if (cap_cnt - base !== 1) begin n_bad++; $display("FAIL flush_frames: got %0d exp 1", cap_cnt - base); end
    n_cmp++; if (cap_mem[base] !== 8'h10) begin n_bad++; $display("FAIL flush_sent: got %h exp 10", cap_mem[base]); end
  endtask

  task automatic test_hold_and_reset();
    int sbase, bad;
    model_en = 1'b0;
    tb_done = 1'b1;
    tb_clr = 1'b0;
    sbase = start_cnt;
    push(8'h5A);
    n_cmp++; if (start_tx !== 1'b0) begin n_bad++; $display("FAIL hold_lat1: got %b exp 0", start_tx); end
    @(negedge clk);
    n_cmp++; if (start_tx !== 1'b1) begin n_bad++; $display("FAIL hold_lat2: got %b exp 1", start_tx); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (start_tx !== 1'b1 || tx_data !== 8'h5A) bad++;
      wr_en = (i == 10 || i == 20);
      wr_data = (i == 10) ? 8'h5B : 8'h5C;
      @(negedge clk);
    end
    wr_en = 1'b0;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL hold_stable: bad cycles=%0d exp 0", bad); end
    n_cmp++; if (level !== 5'd2) begin n_bad++; $display("FAIL hold_level: got %0d exp 2", level); end
    n_cmp++; if (start_cnt - sbase !== 1) begin n_bad++; $display("FAIL hold_pulses: got %0d exp 1", start_cnt - sbase); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (start_tx !== 1'b0) begin n_bad++; $display("FAIL mrst_start: got %b exp 0", start_tx); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL mrst_data: got %h exp 00", tx_data); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL mrst_level: got %0d exp 0", level); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mrst_empty: got %b exp 1", empty); end
    @(negedge clk);
    reset_n = 1'b1;
    sbase = start_cnt;
    repeat (20) @(negedge clk);
    n_cmp++; if (start_cnt - sbase !== 0) begin n_bad++; $display("FAIL mrst_spurious: pulses=%0d exp 0", start_cnt - sbase); end
    push(8'h77);
    @(negedge clk);
    n_cmp++; if (start_tx !== 1'b1) begin n_bad++; $display("FAIL mrst_idle_start: got %b exp 1", start_tx); end
    n_cmp++; if (tx_data !== 8'h77) begin n_bad++; $display("FAIL mrst_idle_data: got %h exp 77", tx_data); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_overflow();
    test_same_cycle_wrap();
    test_flush_in_req();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
